// File: rtl/apu_pkg.sv
// Shared APU constants: frame-sequencer step values, register addresses and step decode.
// APU_FRAME_PAL_EN selects PAL step timing; NTSC is the default.
package apu_pkg;

  typedef enum logic {seq_4step = 1'b0, seq_5step = 1'b1} seq_mode_type;

  typedef struct packed {
    logic q;
    logic h;
    logic irq;
    logic wrap;
  } step_evt_type;

  localparam logic [15:0] ADDR_STATUS = 16'h4015;
  localparam logic [15:0] ADDR_FRAME  = 16'h4017;

`ifdef APU_FRAME_PAL_EN
  localparam logic [15:0] STEP_Q1   = 16'd8313;
  localparam logic [15:0] STEP_QH2  = 16'd16627;
  localparam logic [15:0] STEP_Q3   = 16'd24939;
  localparam logic [15:0] STEP4_IRQ = 16'd33252;
  localparam logic [15:0] STEP4_QHI = 16'd33253;
  localparam logic [15:0] STEP4_END = 16'd33254;
  localparam logic [15:0] STEP5_QH  = 16'd41565;
  localparam logic [15:0] STEP5_END = 16'd41566;
`else
  localparam logic [15:0] STEP_Q1   = 16'd7457;
  localparam logic [15:0] STEP_QH2  = 16'd14913;
  localparam logic [15:0] STEP_Q3   = 16'd22371;
  localparam logic [15:0] STEP4_IRQ = 16'd29828;
  localparam logic [15:0] STEP4_QHI = 16'd29829;
  localparam logic [15:0] STEP4_END = 16'd29830;
  localparam logic [15:0] STEP5_QH  = 16'd37281;
  localparam logic [15:0] STEP5_END = 16'd37282;
`endif

  // Events for the current count, evaluated before the increment.
  function automatic step_evt_type step_decode(input logic [15:0] cyc, input seq_mode_type mode);
    step_evt_type evt;
    evt = '0;
    if (cyc == STEP_Q1 || cyc == STEP_Q3) begin
      evt.q = 1'b1;
    end
    if (cyc == STEP_QH2) begin
      evt.q = 1'b1;
      evt.h = 1'b1;
    end
    if (mode == seq_4step) begin
      if (cyc == STEP4_IRQ || cyc == STEP4_END) begin
        evt.irq = 1'b1;
      end
      if (cyc == STEP4_QHI) begin
        evt.q   = 1'b1;
        evt.h   = 1'b1;
        evt.irq = 1'b1;
      end
      if (cyc == STEP4_END) begin
        evt.wrap = 1'b1;
      end
    end else begin
      if (cyc == STEP5_QH) begin
        evt.q = 1'b1;
        evt.h = 1'b1;
      end
      if (cyc == STEP5_END) begin
        evt.wrap = 1'b1;
      end
    end
    return evt;
  endfunction

endpackage

// File: rtl/apu_frame_counter_if.sv
// CPU-side bus bundle seen by the frame counter: phase-2, address, data, direction and read-back.
interface apu_frame_counter_if;
  logic        I_phy2;
  logic [15:0] I_addr;
  logic [7:0]  I_wr_data;
  logic        I_rdwr;
  logic [7:0]  O_rd_data;
  logic        O_rd_en;

  modport master (
    output I_phy2, I_addr, I_wr_data, I_rdwr,
    input  O_rd_data, O_rd_en
  );

  modport slave (
    input  I_phy2, I_addr, I_wr_data, I_rdwr,
    output O_rd_data, O_rd_en
  );
endinterface

// File: rtl/apu_phy2_edge.sv
// CPU-cycle tick: one-clock strobe on the falling edge of phase-2, shared by the APU channels.
module apu_phy2_edge (
  input  logic clk,
  input  logic srst,
  input  logic phy2,
  output logic tick
);
  logic phy2_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      phy2_reg <= 1'b0;
    end else begin
      phy2_reg <= phy2;
    end
  end

  assign tick = phy2_reg & ~phy2;
endmodule

// File: rtl/apu_frame_counter.sv
// 2A03 frame sequencer: $4017 control, $4015 IRQ status, quarter/half-frame clocks, frame IRQ.
// Step timing is NTSC unless APU_FRAME_PAL_EN is defined (see apu_pkg).
module apu_frame_counter
  import apu_pkg::*;
#(
  parameter int P_PULSE_W = 1
) (
  input  logic               I_clock,
  input  logic               I_reset,
  apu_frame_counter_if.slave bus,
  output logic               O_quarter,
  output logic               O_half,
  output logic               O_irq
);
  localparam int CNT_W = (P_PULSE_W > 1) ? $clog2(P_PULSE_W) : 1;

  logic         tick;
  logic         wr_frame;
  logic         rd_status;
  logic         inhibit_eff;
  logic         irq_set;
  logic         irq_clr;
  logic [1:0]   fire;
  logic [1:0]   pulse;
  step_evt_type evt;

  seq_mode_type mode_reg, mode_next;
  logic         inhibit_reg, inhibit_next;
  logic         parity_reg, parity_next;
  logic         irq_reg, irq_next;
  logic [15:0]  cyc_reg, cyc_next;
  logic [2:0]   rst_dly_reg, rst_dly_next;

  logic unused_wr_data;
  assign unused_wr_data = ^bus.I_wr_data[5:0];

  apu_phy2_edge u_phy2_edge (
    .clk  (I_clock),
    .srst (I_reset),
    .phy2 (bus.I_phy2),
    .tick (tick)
  );

  assign wr_frame  = (bus.I_addr == ADDR_FRAME) & ~bus.I_rdwr;
  assign rd_status = (bus.I_addr == ADDR_STATUS) & bus.I_rdwr;
  assign evt       = step_decode(cyc_reg, mode_reg);

  always_comb begin
    mode_next    = mode_reg;
    inhibit_next = inhibit_reg;
    parity_next  = parity_reg;
    cyc_next     = cyc_reg;
    rst_dly_next = rst_dly_reg;
    irq_next     = irq_reg;
    fire         = 2'b00;
    irq_set      = 1'b0;
    irq_clr      = 1'b0;
    // A write raising inhibit in this tick must also block a set in this tick.
    inhibit_eff  = wr_frame ? bus.I_wr_data[6] : inhibit_reg;
    if (tick) begin
      parity_next = ~parity_reg;
      if (rst_dly_reg == 3'd1) begin
        cyc_next     = '0;
        rst_dly_next = '0;
        if (mode_reg == seq_5step) begin
          fire = 2'b11;
        end
      end else begin
        cyc_next = evt.wrap ? 16'd0 : cyc_reg + 16'd1;
        fire     = {evt.h, evt.q};
        irq_set  = evt.irq & ~inhibit_eff;
        if (rst_dly_reg != 3'd0) begin
          rst_dly_next = rst_dly_reg - 3'd1;
        end
      end
      if (wr_frame) begin
        mode_next    = seq_mode_type'(bus.I_wr_data[7]);
        inhibit_next = bus.I_wr_data[6];
        rst_dly_next = parity_reg ? 3'd4 : 3'd3;
      end
      irq_clr = (wr_frame & bus.I_wr_data[6]) | rd_status;
      if (irq_set) begin
        irq_next = 1'b1;
      end else if (irq_clr) begin
        irq_next = 1'b0;
      end
    end
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      mode_reg    <= seq_4step;
      inhibit_reg <= 1'b0;
      parity_reg  <= 1'b0;
      irq_reg     <= 1'b0;
      cyc_reg     <= '0;
      rst_dly_reg <= '0;
    end else begin
      mode_reg    <= mode_next;
      inhibit_reg <= inhibit_next;
      parity_reg  <= parity_next;
      irq_reg     <= irq_next;
      cyc_reg     <= cyc_next;
      rst_dly_reg <= rst_dly_next;
    end
  end

  // Pulse stretchers: bit 0 quarter-frame, bit 1 half-frame.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pulse
      logic             pulse_reg;
      logic [CNT_W-1:0] hold_reg;

      always_ff @(posedge I_clock) begin
        if (I_reset) begin
          pulse_reg <= 1'b0;
          hold_reg  <= '0;
        end else if (fire[gi]) begin
          pulse_reg <= 1'b1;
          hold_reg  <= CNT_W'(P_PULSE_W - 1);
        end else if (hold_reg != '0) begin
          hold_reg <= hold_reg - CNT_W'(1);
        end else begin
          pulse_reg <= 1'b0;
        end
      end

      assign pulse[gi] = pulse_reg;
    end
  endgenerate

  assign O_quarter     = pulse[0];
  assign O_half        = pulse[1];
  assign O_irq         = irq_reg;
  assign bus.O_rd_en   = rd_status & ~I_reset;
  assign bus.O_rd_data = bus.O_rd_en ? {1'b0, irq_reg, 6'b000000} : 8'h00;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Directed bench for apu_frame_counter (NTSC build): one task per scenario, hand-computed expectations.
`timescale 1ns/1ps
module tb_apu_frame_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic quarter, half, irq;
  logic q_s, h_s, irq_s;
  logic tb_parity;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  apu_frame_counter_if bus();

  apu_frame_counter #(.P_PULSE_W(1)) dut (
    .I_clock   (clk),
    .I_reset   (rst),
    .bus       (bus),
    .O_quarter (quarter),
    .O_half    (half),
    .O_irq     (irq)
  );

  // One CPU cycle: phase-2 high for a clock, then low; the tick registers on the following edge.
  task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bus.I_addr    = a;
    bus.I_rdwr    = rw;
    bus.I_wr_data = d;
    bus.I_phy2    = 1'b1;
    @(negedge clk);
    bus.I_phy2 = 1'b0;
    @(posedge clk);
    #1;
    q_s       = quarter;
    h_s       = half;
    irq_s     = irq;
    tb_parity = ~tb_parity;
    $display("[TB] cycle addr=%h rw=%0d wd=%h -> q=%0d h=%0d irq=%0d", a, rw, d, q_s, h_s, irq_s);
  endtask

  task automatic idle_cycle();
    cpu_cycle(16'h0000, 1'b1, 8'h00);
  endtask

  // Fast-forward the cycle counter during a clock with no tick.
  task automatic jump_cyc(input logic [15:0] v);
    @(negedge clk);
    force dut.cyc_reg = v;
    @(posedge clk);
    #1;
    release dut.cyc_reg;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.I_phy2    = 1'b0;
    bus.I_addr    = 16'h4015;
    bus.I_rdwr    = 1'b1;
    bus.I_wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (quarter !== 1'b0) begin fails++; $display("FAIL reset_quarter: got %b, expected 0", quarter); end
    tests++; if (half !== 1'b0) begin fails++; $display("FAIL reset_half: got %b, expected 0", half); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b, expected 0", irq); end
    tests++; if (bus.O_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b, expected 0", bus.O_rd_en); end
    tests++; if (bus.O_rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data: got %h, expected 00", bus.O_rd_data); end
    tests++; if (dut.cyc_reg !== 16'd0) begin fails++; $display("FAIL reset_cyc: got %0d, expected 0", dut.cyc_reg); end
    @(negedge clk);
    rst = 1'b0;
    tb_parity = 1'b0;
    #1;
    tests++; if (bus.O_rd_en !== 1'b1) begin fails++; $display("FAIL rd_en_decode: got %b, expected 1", bus.O_rd_en); end
    tests++; if (bus.O_rd_data !== 8'h00) begin fails++; $display("FAIL rd_data_idle: got %h, expected 00", bus.O_rd_data); end
    bus.I_addr = 16'h0000;
  endtask

  task automatic test_4step_frame();
    int   q_err = 0;
    int   h_err = 0;
    int   i_err = 0;
    int   first_bad = -1;
    logic exp_q, exp_h, exp_i;
    for (int k = 0; k < 29831; k++) begin
      if (k == 29829) cpu_cycle(16'h4015, 1'b1, 8'h00);
      else idle_cycle();
      exp_q = (k == 7457) || (k == 14913) || (k == 22371) || (k == 29829);
      exp_h = (k == 14913) || (k == 29829);
      exp_i = (k >= 29828);
      if ((q_s !== exp_q || h_s !== exp_h || irq_s !== exp_i) && first_bad < 0) first_bad = k;
      if (q_s !== exp_q) q_err++;
      if (h_s !== exp_h) h_err++;
      if (irq_s !== exp_i) i_err++;
      if (k == 0) begin
        tests++; if (dut.cyc_reg !== 16'd1) begin fails++; $display("FAIL first_count: got %0d, expected 1", dut.cyc_reg); end
      end
      if (k == 7457) begin
        @(posedge clk);
        #1;
        tests++; if (quarter !== 1'b0) begin fails++; $display("FAIL pulse_width: quarter still %b one clock later, expected 0", quarter); end
      end
      if (k == 29829) begin
        tests++; if (irq_s !== 1'b1) begin fails++; $display("FAIL set_clear_collision: irq %b, expected 1", irq_s); end
      end
    end
    tests++; if (q_err != 0) begin fails++; $display("FAIL q_schedule: %0d wrong ticks (first bad tick %0d), expected 0", q_err, first_bad); end
    tests++; if (h_err != 0) begin fails++; $display("FAIL h_schedule: %0d wrong ticks (first bad tick %0d), expected 0", h_err, first_bad); end
    tests++; if (i_err != 0) begin fails++; $display("FAIL irq_schedule: %0d wrong ticks (first bad tick %0d), expected 0", i_err, first_bad); end
    tests++; if (dut.cyc_reg !== 16'd0) begin fails++; $display("FAIL 4step_wrap: cyc %0d, expected 0", dut.cyc_reg); end
  endtask

  task automatic test_read_clear();
    @(negedge clk);
    bus.I_addr = 16'h4015;
    bus.I_rdwr = 1'b1;
    bus.I_phy2 = 1'b1;
    #1;
    tests++; if (bus.O_rd_en !== 1'b1) begin fails++; $display("FAIL read_rd_en: got %b, expected 1", bus.O_rd_en); end
    tests++; if (bus.O_rd_data !== 8'h40) begin fails++; $display("FAIL read_data: got %h, expected 40", bus.O_rd_data); end
    @(negedge clk);
    bus.I_phy2 = 1'b0;
    @(posedge clk);
    #1;
    tb_parity = ~tb_parity;
    $display("[TB] read $4015 tick -> irq=%0d rd_data=%h", irq, bus.O_rd_data);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL read_clear_irq: got %b, expected 0", irq); end
    tests++; if (bus.O_rd_data !== 8'h00) begin fails++; $display("FAIL read_clear_data: got %h, expected 00", bus.O_rd_data); end
  endtask

  task automatic test_odd_parity();
    if (tb_parity == 1'b0) idle_cycle();
    cpu_cycle(16'h4017, 1'b0, 8'h00);
    repeat (3) idle_cycle();
    tests++; if (dut.cyc_reg === 16'd0) begin fails++; $display("FAIL odd_early: cyc %0d after 3 ticks, expected nonzero", dut.cyc_reg); end
    idle_cycle();
    tests++; if (dut.cyc_reg !== 16'd0) begin fails++; $display("FAIL odd_delay4: cyc %0d after 4 ticks, expected 0", dut.cyc_reg); end
    tests++; if (q_s !== 1'b0) begin fails++; $display("FAIL odd_no_pulse: quarter %b in 4-step reset, expected 0", q_s); end
    // Two writes on consecutive ticks (even then odd parity): the second delay of 4 wins.
    if (tb_parity == 1'b1) idle_cycle();
    cpu_cycle(16'h4017, 1'b0, 8'h00);
    cpu_cycle(16'h4017, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      idle_cycle();
      if (i < 4) begin
        tests++; if (dut.cyc_reg === 16'd0) begin fails++; $display("FAIL reload_early: cyc 0 after %0d ticks, expected nonzero", i); end
      end else begin
        tests++; if (dut.cyc_reg !== 16'd0) begin fails++; $display("FAIL reload_delay: cyc %0d after 4 ticks, expected 0", dut.cyc_reg); end
      end
    end
  endtask

  task automatic test_5step();
    int bad = 0;
    if (tb_parity == 1'b1) idle_cycle();
    cpu_cycle(16'h4017, 1'b0, 8'h80);
    idle_cycle();
    idle_cycle();
    tests++; if (q_s !== 1'b0) begin fails++; $display("FAIL 5step_early_pulse: quarter %b at tick 2, expected 0", q_s); end
    idle_cycle();
    tests++; if ({q_s, h_s} !== 2'b11) begin fails++; $display("FAIL 5step_reset_pulse: q/h %b%b, expected 11", q_s, h_s); end
    tests++; if (dut.cyc_reg !== 16'd0) begin fails++; $display("FAIL 5step_reset_cyc: cyc %0d, expected 0", dut.cyc_reg); end
    jump_cyc(16'd7457);
    idle_cycle();
    tests++; if ({q_s, h_s} !== 2'b10) begin fails++; $display("FAIL 5step_q1: q/h %b%b, expected 10", q_s, h_s); end
    jump_cyc(16'd29826);
    for (int k = 29826; k <= 29831; k++) begin
      idle_cycle();
      if (q_s !== 1'b0 || h_s !== 1'b0 || irq_s !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL 5step_no_4step_events: %0d bad ticks, expected 0", bad); end
    tests++; if (dut.cyc_reg !== 16'd29832) begin fails++; $display("FAIL 5step_no_wrap: cyc %0d, expected 29832", dut.cyc_reg); end
    bad = 0;
    jump_cyc(16'd37279);
    for (int k = 37279; k <= 37282; k++) begin
      idle_cycle();
      if (q_s !== (k == 37281) || h_s !== (k == 37281) || irq_s !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL 5step_end_events: %0d bad ticks, expected 0", bad); end
    tests++; if (dut.cyc_reg !== 16'd0) begin fails++; $display("FAIL 5step_wrap: cyc %0d, expected 0", dut.cyc_reg); end
  endtask

  task automatic test_inhibit();
    int irq_seen;
    int q_seen;
    cpu_cycle(16'h4017, 1'b0, 8'h00);
    repeat (4) idle_cycle();
    jump_cyc(16'd29827);
    idle_cycle();
    idle_cycle();
    tests++; if (irq_s !== 1'b1) begin fails++; $display("FAIL inhibit_pre_irq: irq %b, expected 1", irq_s); end
    cpu_cycle(16'h4017, 1'b0, 8'h40);
    tests++; if (irq_s !== 1'b0) begin fails++; $display("FAIL inhibit_clear: irq %b, expected 0", irq_s); end
    repeat (4) idle_cycle();
    for (int f = 0; f < 2; f++) begin
      irq_seen = 0;
      q_seen   = 0;
      jump_cyc(16'd29826);
      for (int k = 29826; k <= 29830; k++) begin
        idle_cycle();
        if (irq_s !== 1'b0) irq_seen++;
        if (k == 29829 && q_s === 1'b1 && h_s === 1'b1) q_seen++;
      end
      tests++; if (irq_seen != 0) begin fails++; $display("FAIL inhibit_frame%0d_irq: %0d ticks with irq, expected 0", f, irq_seen); end
      tests++; if (q_seen != 1) begin fails++; $display("FAIL inhibit_frame%0d_qh: %0d pulses at 29829, expected 1", f, q_seen); end
      tests++; if (dut.cyc_reg !== 16'd0) begin fails++; $display("FAIL inhibit_frame%0d_wrap: cyc %0d, expected 0", f, dut.cyc_reg); end
    end
  endtask

  task automatic test_reset_mid();
    int q_seen = 0;
    cpu_cycle(16'h4017, 1'b0, 8'h00);
    repeat (4) idle_cycle();
    jump_cyc(16'd29827);
    idle_cycle();
    idle_cycle();
    tests++; if (irq_s !== 1'b1) begin fails++; $display("FAIL mid_pre_irq: irq %b, expected 1", irq_s); end
    jump_cyc(16'd19998);
    cpu_cycle(16'h4017, 1'b0, 8'h80);
    idle_cycle();
    tests++; if (dut.cyc_reg !== 16'd20000) begin fails++; $display("FAIL mid_pre_cyc: cyc %0d, expected 20000", dut.cyc_reg); end
    @(negedge clk);
    rst        = 1'b1;
    bus.I_addr = 16'h4015;
    bus.I_rdwr = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset at cyc 20000 -> q=%0d h=%0d irq=%0d rd_en=%0d", quarter, half, irq, bus.O_rd_en);
    tests++; if ({quarter, half, irq, bus.O_rd_en} !== 4'b0000) begin fails++; $display("FAIL mid_reset_outputs: q/h/irq/rd_en %b%b%b%b, expected 0000", quarter, half, irq, bus.O_rd_en); end
    tests++; if (bus.O_rd_data !== 8'h00) begin fails++; $display("FAIL mid_reset_rd_data: got %h, expected 00", bus.O_rd_data); end
    tests++; if (dut.cyc_reg !== 16'd0) begin fails++; $display("FAIL mid_reset_cyc: cyc %0d, expected 0", dut.cyc_reg); end
    @(negedge clk);
    rst        = 1'b0;
    bus.I_addr = 16'h0000;
    tb_parity  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle_cycle();
      if (q_s === 1'b1) q_seen++;
    end
    tests++; if (dut.cyc_reg !== 16'd6) begin fails++; $display("FAIL mid_dly_abandoned: cyc %0d after 6 ticks, expected 6", dut.cyc_reg); end
    tests++; if (q_seen != 0) begin fails++; $display("FAIL mid_no_pulse: %0d pulses, expected 0", q_seen); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_4step_frame();
    test_read_clear();
    test_odd_parity();
    test_5step();
    test_inhibit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apu_frame_counter.md
# apu_frame_counter

Frame sequencer for the 2A03 APU. Decodes CPU bus writes to $4017 and reads of $4015. Counts CPU cycles and emits quarter-frame and half-frame clock pulses for the envelope, length and sweep units. Drives the frame-interrupt level that feeds the core's `I_irq` input, sitting alongside the OAM-DMA/CPU core on the same bus.

## Interface
Parameters:
- `P_PULSE_W`, 1: width of quarter/half pulses, in `I_clock` cycles.

Ports:
- `I_clock`  in  1  system clock. One clock; all state on its rising edge.
- `I_reset`  in  1  reset; synchronous, active-high.
- `I_phy2`  in  1  CPU phase-2 from the core. A CPU cycle ends on its falling edge.
- `I_addr`  in  16  CPU bus address.
- `I_wr_data`  in  8  CPU write data.
- `I_rdwr`  in  1  1 = read, 0 = write.
- `O_rd_data`  out  8  read data. Bit 6 = frame IRQ flag; all other bits 0.
- `O_rd_en`  out  1  1 while `I_addr`==16'h4015 and `I_rdwr`=1 (combinational).
- `O_quarter`  out  1  quarter-frame pulse.
- `O_half`  out  1  half-frame pulse.
- `O_irq`  out  1  frame interrupt level, active-high.

## Operation
- **CPU-cycle tick.** `tick` = `I_phy2` falling edge, detected from a registered copy of `I_phy2`. All counter, flag and register updates happen only on `tick`.
- **Registers:** `mode` (0 = 4-step, 1 = 5-step), `inhibit`, `cyc[15:0]`, `parity`, `irq_flag`, `rst_dly[2:0]`.
- **Parity.** `parity` toggles every tick.
- **$4017 write** (`I_addr`==16'h4017, `I_rdwr`=0, latched on tick):
  - `mode` ← `I_wr_data[7]`, `inhibit` ← `I_wr_data[6]`.
  - If bit 6 = 1, `irq_flag` clears.
  - `rst_dly` loads 3 if `parity`=0, else 4.
- **Delayed reset.** When `rst_dly` reaches 1, on the next tick: `cyc` ← 0 and `rst_dly` ← 0. If `mode`=1, quarter and half pulses fire in that same tick.
- **Normal counting.** Otherwise `cyc` increments on each tick.
- **Step compare (NTSC).** `cyc` is compared before the increment.
  - 4-step:
    - 7457 Q
    - 14913 Q+H
    - 22371 Q
    - 29828 set IRQ
    - 29829 Q+H, set IRQ
    - 29830 set IRQ, `cyc` ← 0
  - 5-step:
    - 7457 Q
    - 14913 Q+H
    - 22371 Q
    - 37281 Q+H
    - 37282 `cyc` ← 0
    - No IRQ is ever set in 5-step mode.
- **IRQ set** only when `inhibit`=0.
- **$4015 read.** Clears `irq_flag` on the tick ending the read cycle. If a set and a clear fall on the same tick, set wins.
- **Output mapping.**
  - `O_irq` = `irq_flag`.
  - `O_rd_data` = {1'b0, `irq_flag`, 6'b0} while `O_rd_en`=1, else 8'h00.
- **Reset.**
  - `cyc`, `mode`, `inhibit`, `irq_flag`, `parity`, `rst_dly` = 0.
  - `O_quarter`, `O_half`, `O_irq`, `O_rd_data`, `O_rd_en` = 0.
  - Reset mid-frame abandons any pending `rst_dly` and any pulse in flight.

## Timing
- Q/H pulses: asserted on the `I_clock` edge that registers the tick, held `P_PULSE_W` clocks, then 0.
- `O_irq` rises one `I_clock` after the setting tick.
- **Write-to-reset latency:** 3 or 4 CPU cycles after the write tick, per `parity`.
- **Second $4017 write** during a pending delay reloads `rst_dly`; the previous delay is cancelled.
- **Overlap of delayed reset and a step value:** the reset takes priority; the step does not fire.
- **Counter width:** `cyc` never exceeds 37282 (41566 PAL). No wrap beyond 16 bits is possible.

## Configuration
- Macro `APU_FRAME_PAL_EN`.
- **Defined:** PAL step constants.
  - 4-step: 8313 Q; 16627 Q+H; 24939 Q; 33252 IRQ; 33253 Q+H+IRQ; 33254 IRQ+reset.
  - 5-step: 8313 Q; 16627 Q+H; 24939 Q; 41565 Q+H; 41566 reset.
- **Undefined:** NTSC constants as listed in Operation.
- All other behaviour is identical.

## Structure
- **Package `apu_pkg`:**
  - Step constants, NTSC and PAL, selected by the macro.
  - `typedef enum logic {seq_4step, seq_5step} seq_mode_type`.
  - Register addresses 16'h4015 and 16'h4017.
- **Sub-module `apu_phy2_edge`:** the registered `I_phy2` and fall-detect. Outputs `tick`; reused by the other APU channels.

## Test plan
- **4-step IRQ:** reset, then 29831 ticks with no writes. Expect:
  - Q at `cyc` 7457, 14913, 22371, 29829.
  - H at 14913 and 29829.
  - `O_irq`=1 from tick 29828.
  - `cyc`=0 after 29830.
- **Read clear:** with `O_irq`=1, read $4015. Expect `O_rd_data`=8'h40 and `O_rd_en`=1 during the cycle; `O_irq`=0 after the tick.
- **5-step mode:** write 8'h80 to $4017 on an even-parity tick. Expect:
  - Q+H pulse 3 ticks later and `cyc`=0.
  - Next Q+H at 37281.
  - `O_irq` stays 0 throughout.
- **Inhibit:** write 8'h40 with `O_irq`=1. Expect `O_irq`=0 next clock and no IRQ through two full 4-step frames.
- **Odd-parity write:** write 8'h00 on an odd-parity tick. Expect `cyc`=0 exactly 4 ticks later; a second write 1 tick after the first restarts the delay.
- **Set vs. clear collision and reset:**
  - $4015 read on `cyc`=29829 → `O_irq` remains 1.
  - `I_reset` asserted at `cyc`=20000 → all outputs 0 and `cyc`=0 the next clock.
